// File: rtl/mult_pkg.sv
// Shared types and helpers for the parametrised sequential multiplier.
// The index width is sized to hold chunk numbers 0..N-1, never narrower than one bit.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_seq_fsm.sv
// Sequencer for the chunked multiplier: walks the (i, j) chunk pairs and owns the
// busy/done handshake plus the load, accumulate and finalise strobes for the datapath.
module mult_seq_fsm
    import mult_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] i_idx,
    output logic [IW-1:0] j_idx,
    output logic          load,
    output logic          accum,
    output logic          finalise
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_e        state_r;
    logic [IW-1:0] i_r;
    logic [IW-1:0] j_r;
    logic          busy_r;
    logic          done_r;

    // State, chunk indices and handshake outputs; j is the inner index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            i_r     <= '0;
            j_r     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    i_r    <= '0;
                    j_r    <= '0;
                    if (start) begin
                        state_r <= CALC;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                CALC: begin
                    done_r <= 1'b0;
                    if (j_r == LAST) begin
                        j_r <= '0;
                        if (i_r == LAST) begin
                            i_r     <= '0;
                            state_r <= FINAL;
                        end else begin
                            i_r <= i_r + 1'b1;
                        end
                    end else begin
                        j_r <= j_r + 1'b1;
                    end
                end
                FINAL: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    i_r     <= '0;
                    j_r     <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign i_idx    = i_r;
    assign j_idx    = j_r;
    // Load fires in any idle cycle with start, including the done cycle (back-to-back)
    assign load     = (state_r == IDLE) & start;
    assign accum    = (state_r == CALC);
    assign finalise = (state_r == FINAL);

endmodule

// File: rtl/mult_seq_param.sv
// Multi-cycle WIDTH x WIDTH multiplier: one CHUNK x CHUNK partial product per cycle on
// operand magnitudes, sign applied once at the end. Product only changes on completion.
module mult_seq_param
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = idx_width(N);
    localparam int SW = $clog2(2 * WIDTH) + 1;

    if (((WIDTH % CHUNK) != 0) || (WIDTH < CHUNK)) begin : g_param_check
        $error("mult_seq_param: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic [IW-1:0]      i_s;
    logic [IW-1:0]      j_s;
    logic               load_s;
    logic               accum_s;
    logic               finalise_s;

    logic               sign_a_s;
    logic               sign_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [CHUNK-1:0]   a_chunk_s [N];
    logic [CHUNK-1:0]   b_chunk_s [N];
    logic [2*CHUNK-1:0] pp_s;
    logic [SW-1:0]      shift_s;
    logic [2*WIDTH-1:0] term_s;

    logic               sign_a_r;
    logic               sign_b_r;
    logic [WIDTH-1:0]   mag_a_r;
    logic [WIDTH-1:0]   mag_b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] product_r;

    mult_seq_fsm #(
        .N  (N),
        .IW (IW)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .i_idx    (i_s),
        .j_idx    (j_s),
        .load     (load_s),
        .accum    (accum_s),
        .finalise (finalise_s)
    );

    // The most negative operand's magnitude still fits in WIDTH unsigned bits
    assign sign_a_s = signed_mode & a[WIDTH-1];
    assign sign_b_s = signed_mode & b[WIDTH-1];
    assign mag_a_s  = sign_a_s ? (~a + 1'b1) : a;
    assign mag_b_s  = sign_b_s ? (~b + 1'b1) : b;

    for (genvar k = 0; k < N; k++) begin : g_chunk
        assign a_chunk_s[k] = mag_a_r[k*CHUNK +: CHUNK];
        assign b_chunk_s[k] = mag_b_r[k*CHUNK +: CHUNK];
    end

    // Current partial product, aligned to bit CHUNK*(i+j) of the accumulator
    always_comb begin
        pp_s    = (2*CHUNK)'(a_chunk_s[i_s]) * (2*CHUNK)'(b_chunk_s[j_s]);
        shift_s = (SW'(i_s) + SW'(j_s)) * SW'(CHUNK);
        term_s  = (2*WIDTH)'(pp_s) << shift_s;
    end

    // Operand latch, accumulation and final signed product
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            mag_a_r   <= '0;
            mag_b_r   <= '0;
            acc_r     <= '0;
            product_r <= '0;
        end else begin
            if (load_s) begin
                sign_a_r <= sign_a_s;
                sign_b_r <= sign_b_s;
                mag_a_r  <= mag_a_s;
                mag_b_r  <= mag_b_s;
                acc_r    <= '0;
            end else if (accum_s) begin
                acc_r <= acc_r + term_s;
            end else if (finalise_s) begin
                product_r <= (sign_a_r ^ sign_b_r) ? (~acc_r + 1'b1) : acc_r;
            end
        end
    end

    assign product = product_r;

endmodule

// File: tb/tb_mult_seq_param.sv
// Self-checking bench: three multiplier configurations, each checked every cycle against
// a cycle-count/arithmetic reference model, plus directed literal cases on the default one.
module tb_mult_seq_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int W = (g == 2) ? 16 : 32;
        localparam int C = (g == 0) ? 8 : ((g == 1) ? 16 : 4);
        localparam int K = (W / C) * (W / C);

        logic           rst_n = 1'b0;
        logic           start = 1'b0;
        logic           sm = 1'b0;
        logic [W-1:0]   a = '0;
        logic [W-1:0]   b = '0;
        logic           busy;
        logic           done;
        logic [2*W-1:0] product;
        logic           fin = 1'b0;

        mult_seq_param #(.WIDTH(W), .CHUNK(C)) dut (
            .clk         (clk),
            .reset       (rst_n),
            .start       (start),
            .signed_mode (sm),
            .a           (a),
            .b           (b),
            .busy        (busy),
            .done        (done),
            .product     (product)
        );

        function automatic logic [2*W-1:0] ref_mul(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
            logic [2*W-1:0] ex;
            logic [2*W-1:0] ey;
            ex = m ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
            ey = m ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
            return ex * ey;
        endfunction

        // Reference: an accepted start produces done K+1 edges later; busy until then
        int             rem = 0;
        logic           take = 1'b0;
        logic           exp_busy = 1'b0;
        logic           exp_done = 1'b0;
        logic [2*W-1:0] exp_prod = '0;
        logic [2*W-1:0] pend = '0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rem      = 0;
                exp_busy = 1'b0;
                exp_done = 1'b0;
                exp_prod = '0;
            end else begin
                take     = start && (rem == 0);
                exp_done = 1'b0;
                if (rem > 0) begin
                    rem--;
                    if (rem == 0) begin
                        exp_done = 1'b1;
                        exp_prod = pend;
                    end
                end
                if (take) begin
                    rem  = K + 1;
                    pend = ref_mul(sm, a, b);
                end
                exp_busy = (rem > 0);
            end
        end

        always @(negedge clk) begin
            check($sformatf("g%0d.busy", g), busy, exp_busy);
            check($sformatf("g%0d.done", g), done, exp_done);
            check($sformatf("g%0d.product", g), product, exp_prod);
        end

        function automatic logic [W-1:0] rnd_op();
            case ($urandom_range(0, 7))
                0:       return '0;
                1:       return '1;
                2:       return {1'b1, {(W-1){1'b0}}};
                3:       return {1'b0, {(W-1){1'b1}}};
                default: return W'($urandom);
            endcase
        endfunction

        task automatic wait_done(input int c0, output int lat, output int nbusy);
            lat   = 0;
            nbusy = 0;
            for (int c = c0; c <= c0 + K + 20; c++) begin
                if (busy) nbusy++;
                if (done) begin
                    lat = c;
                    break;
                end
                @(posedge clk); #1;
            end
        endtask

        // Called at #1 after an edge; start is sampled at the following edge
        task automatic run_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                              output int lat, output int nbusy);
            sm = m; a = x; b = y; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            sm = 1'($urandom); a = W'($urandom); b = W'($urandom);
            wait_done(1, lat, nbusy);
        endtask

        task automatic rand_ops(input int n);
            int lat;
            int nb;
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                run_op(1'($urandom), rnd_op(), rnd_op(), lat, nb);
                check($sformatf("g%0d.rand_latency", g), lat, K + 2);
            end
        endtask

        if (g == 0) begin : drv
            initial begin
                int lat;
                int nb;
                int nd;
                repeat (3) @(posedge clk);
                #1;
                check("reset_busy", busy, 1'b0);
                check("reset_done", done, 1'b0);
                check("reset_product", product, 64'h0);
                rst_n = 1'b1;
                @(posedge clk); #1;

                run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nb);
                check("umax_product", product, 64'hFFFF_FFFE_0000_0001);
                check("umax_latency", lat, 18);
                check("umax_busy_cycles", nb, 17);
                run_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0005, lat, nb);
                check("s_m1x5", product, 64'hFFFF_FFFF_FFFF_FFFB);
                check("b2b_latency", lat, 18);
                run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0005, lat, nb);
                check("u_ffx5", product, 64'h0000_0004_FFFF_FFFB);
                run_op(1'b1, 32'h8000_0000, 32'h8000_0000, lat, nb);
                check("s_min_sq", product, 64'h4000_0000_0000_0000);
                run_op(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, lat, nb);
                check("s_min_max", product, 64'hC000_0000_8000_0000);

                // Start pulse mid-CALC must not disturb the running operation
                @(posedge clk); #1;
                sm = 1'b0; a = 32'd3; b = 32'd7; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                sm = 1'b1; a = 32'd100; b = 32'd100; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                wait_done(7, lat, nb);
                check("ignore_start_product", product, 64'd21);
                check("ignore_start_latency", lat, 18);

                // Reset in the seventh CALC cycle aborts with no done
                @(posedge clk); #1;
                sm = 1'b0; a = 32'hFFFF; b = 32'hFFFF; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                repeat (6) begin @(posedge clk); #1; end
                rst_n = 1'b0;
                #1;
                check("abort_busy", busy, 1'b0);
                check("abort_done", done, 1'b0);
                check("abort_product", product, 64'h0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                nd = 0;
                repeat (K + 4) begin
                    @(posedge clk); #1;
                    if (done) nd++;
                end
                check("abort_no_done", nd, 0);
                run_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, lat, nb);
                check("after_abort_product", product, 64'hFFFF_FFFF_FFFF_FFEB);
                check("after_abort_latency", lat, 18);

                rand_ops(60);
                fin = 1'b1;
            end
        end else begin : drv
            initial begin
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                rand_ops(200);
                fin = 1'b1;
            end
        end
    end

    initial begin
        for (int c = 0; c < 60000; c++) begin
            @(posedge clk);
            if (gi[0].fin && gi[1].fin && gi[2].fin) break;
        end
        #2;
        check("all_finished", {gi[0].fin, gi[1].fin, gi[2].fin}, 3'b111);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_seq_param.md
Name: mult_seq_param

Overview:
Parametrised multi-cycle integer multiplier. It is the successor to the fixed 32x32 sequential multiplier.
- Generalised in operand width and partial-product chunk width.
- Adds a per-operation signed/unsigned mode, a one-cycle done pulse, a product register that holds its value during computation, and back-to-back starts.
- Sits beside the datapath as a shared arithmetic resource. Start/busy/done handshake.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of CHUNK and >= CHUNK.
- CHUNK, 8, partial-product chunk width. One CHUNKxCHUNK multiply per cycle.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while idle
- signed_mode  in  1  1 = operands are two's complement; 0 = unsigned. Sampled with start.
- a  in  WIDTH  multiplicand; sampled with start
- b  in  WIDTH  multiplier; sampled with start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when product is updated
- product  out  2*WIDTH  result; holds its last value until the next completion

Behaviour:
- Definitions: N = WIDTH/CHUNK; K = N*N.
- Reset (reset low, asynchronous): state IDLE, busy=0, done=0, product=0. Accumulator, indices and latched operands are cleared.
- States: IDLE -> CALC -> FINAL -> IDLE.
- IDLE, start=1 at edge T:
  - latch sign_a = signed_mode & a[WIDTH-1], and likewise sign_b
  - latch |a| and |b| as WIDTH-bit unsigned magnitudes; unsigned mode uses the raw operands
  - clear the 2*WIDTH accumulator; set chunk indices i=j=0; go to CALC
  - -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits; no overflow case.
- CALC, one partial product per cycle:
  - acc += (magA chunk i * magB chunk j) << (CHUNK*(i+j))
  - j is the inner index: j increments; at N-1 it wraps to 0 and i increments.
  - After the step with i=j=N-1, go to FINAL. CALC lasts exactly K cycles.
- FINAL, one cycle:
  - product <= (sign_a ^ sign_b) ? -acc : acc, taken modulo 2^(2*WIDTH)
  - done <= 1; go to IDLE
- Timing:
  - busy is registered, high in CALC and FINAL: cycles T+1 .. T+K+1.
  - product and done are valid in cycle T+K+2; busy is low in that cycle.
  - Total latency is K+2 cycles from the start edge to done: 18 for the defaults, 6 for CHUNK=16.
- done is high for exactly one cycle. It also clears when a new start is accepted in that same cycle.
- start while busy: ignored; no effect on operands or sequence.
- start in the done cycle: accepted (back-to-back). The new operation begins. product keeps the previous result until the new FINAL.
- product never shows intermediate values. It only changes at reset or in FINAL.
- signed_mode, a and b may change freely after the start edge.
- A zero operand still takes the full K+2 cycles; there is no early termination.
- Reset mid-operation: abort immediately. All outputs take their reset values and no done is generated.
- Elaboration: a static assertion fails if WIDTH % CHUNK != 0.

Decomposition:
- Package mult_pkg: state enum typedef (IDLE, CALC, FINAL) and a helper function computing the index width, $clog2(N) with minimum 1.
- One sub-module, mult_seq_fsm: holds the state register, the i/j counters, busy, done, and the load/accumulate/finalise strobes.
- The top level holds the operand, sign, accumulator and product registers, plus the chunk multiply/shift logic.

Test Plan:
- Unsigned max: W=32, C=8, signed_mode=0, a=b=0xFFFFFFFF -> product 0xFFFFFFFE00000001; done exactly 18 cycles after the start edge; busy high for 17 cycles.
- Signed mixed: signed_mode=1, a=0xFFFFFFFF (-1), b=5 -> product 0xFFFFFFFFFFFFFFFB. The same operands with signed_mode=0 -> 0x00000004FFFFFFFB.
- Signed extreme: signed_mode=1, a=b=0x80000000 -> 0x4000000000000000. Then a=0x80000000, b=0x7FFFFFFF -> 0xC000000080000000.
- Handshake:
  - a start pulse mid-CALC with different operands is ignored; the result equals the first operation's product
  - a start in the done cycle yields a second correct result 18 cycles later
  - product is stable between the two done pulses
- Reset mid-op: assert reset at cycle 7 of CALC -> busy, done and product go to 0 immediately and no done follows. After release, a new start completes correctly.
- Parameter sweep: C=16 (latency 6) and W=16, C=4 (latency 18), each with ~200 random signed and unsigned operand pairs checked against a reference model.
